// File: rtl/aes_pkg.sv
// Shared AES constants, state encoding and S-box lookup, used by both key schedules.
package aes_pkg;

    localparam int NK = 8;   // key words (AES-256)
    localparam int NR = 14;  // number of rounds

    // Inverse key-schedule controller states
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EMIT = 2'd1,
        ST_GEN  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    // Round constants, indexed by i/NK (entry 0 unused)
    localparam logic [7:0] RCON [8] = '{
        8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40
    };

    localparam logic [7:0] SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    function automatic logic [7:0] sbox(input logic [7:0] x);
        return SBOX[x];
    endfunction

endpackage

// File: rtl/aes_subword.sv
// SubWord: byte-wise S-box substitution of one 32-bit word, purely combinational.
module aes_subword
    import aes_pkg::*;
(
    input  logic [31:0] word,
    output logic [31:0] sub
);

    // Four independent S-box lookups, MSB byte first
    always_comb begin
        sub = {sbox(word[31:24]), sbox(word[23:16]), sbox(word[15:8]), sbox(word[7:0])};
    end

endmodule

// File: rtl/aes256_inv_key_schedule.sv
// AES-256 key schedule run backwards: from w[52..59] regenerates round keys
// 14 down to 0, one schedule word per cycle.
//
// Handshake: key_valid is held high with key_out/round_idx stable until the
// cycle where key_valid & key_ready are both high at posedge clk; that edge
// transfers the key. key_valid never depends combinationally on key_ready.
module aes256_inv_key_schedule
    import aes_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [255:0] key_in,
    input  logic         key_ready,
    output logic         key_valid,
    output logic [127:0] key_out,
    output logic [3:0]   round_idx,
    output logic         busy,
    output logic         done
);

    localparam logic [3:0] LAST_ROUND = 4'(NR);
    localparam logic [5:0] J_START    = 6'(NK * 6 + 4);  // window starts at w52

    state_t      state, state_d;
    logic [31:0] win [NK];    // win[k] holds w[j+k]
    logic [5:0]  j;
    logic [3:0]  r;
    logic [2:0]  cnt;
    logic        load, step, accept;

    logic [5:0]  i_idx;
    logic [31:0] t_in, t_sub, t_word, new_word;

    // Backward step: w[j-1] = w[j+7] ^ T(w[j+6]) with T chosen by i = j+7
    always_comb begin
        i_idx  = j + 6'd7;
        t_in   = (i_idx[2:0] == 3'd0) ? {win[6][23:0], win[6][31:24]} : win[6];
        t_word = win[6];
        if (i_idx[2:0] == 3'd0) begin
            t_word = t_sub ^ {RCON[i_idx[5:3]], 24'h0};
        end else if (i_idx[2:0] == 3'd4) begin
            t_word = t_sub;
        end
        new_word = win[7] ^ t_word;
    end

    aes_subword u_subword (
        .word (t_in),
        .sub  (t_sub)
    );

    // State register
    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_d;
    end

    // Next-state and control strobes
    always_comb begin
        state_d = state;
        load    = 1'b0;
        step    = 1'b0;
        accept  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    load    = 1'b1;
                    state_d = ST_EMIT;
                end
            end
            ST_EMIT: begin
                if (key_ready) begin
                    accept = 1'b1;
                    if (r == 4'd0)            state_d = ST_DONE;
                    else if (r != LAST_ROUND) state_d = ST_GEN;
                end
            end
            ST_GEN: begin
                step = 1'b1;
                if (cnt == 3'd1) state_d = ST_EMIT;
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Window, word index, round and step counter
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < NK; k++) win[k] <= '0;
            j   <= '0;
            r   <= '0;
            cnt <= '0;
        end else begin
            if (load) begin
                for (int k = 0; k < NK; k++) win[k] <= key_in[255 - 32*k -: 32];
                j <= J_START;
                r <= LAST_ROUND;
            end
            if (accept && r != 4'd0) begin
                r <= r - 4'd1;
                if (r != LAST_ROUND) cnt <= 3'd4;
            end
            if (step) begin
                for (int k = 1; k < NK; k++) win[k] <= win[k-1];
                win[0] <= new_word;
                j      <= j - 6'd1;
                cnt    <= cnt - 3'd1;
            end
        end
    end

    // Outputs decode registered state only; rk14 sits in the upper half of the window
    always_comb begin
        key_valid = (state == ST_EMIT);
        key_out   = '0;
        if (key_valid) begin
            key_out = (r == LAST_ROUND) ? {win[4], win[5], win[6], win[7]}
                                        : {win[0], win[1], win[2], win[3]};
        end
        round_idx = r;
        busy      = (state == ST_EMIT) || (state == ST_GEN);
        done      = (state == ST_DONE);
    end

endmodule

// File: tb/tb_aes256_inv_key_schedule.sv
// Self-checking bench for aes256_inv_key_schedule: forward-expansion model,
// expected-key queue, directed scenarios in one initial block.
module tb_aes256_inv_key_schedule;
    import aes_pkg::*;

    // ---------------- clock / reset ----------------
    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [255:0] key_in;
    logic         key_ready;
    logic         key_valid;
    logic [127:0] key_out;
    logic [3:0]   round_idx;
    logic         busy;
    logic         done;

    always #5 clk = ~clk;

    aes256_inv_key_schedule dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .key_in    (key_in),
        .key_ready (key_ready),
        .key_valid (key_valid),
        .key_out   (key_out),
        .round_idx (round_idx),
        .busy      (busy),
        .done      (done)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- bookkeeping ----------------
    int             n_checks = 0;
    int             n_fail   = 0;
    logic [131:0]   exp_q[$];       // {round, key}
    int             exp_cyc_q[$];   // expected cycle offset of each key
    int             t0 = 0;
    bit             timed = 1'b0;
    bit             ready_rand = 1'b0;
    logic [127:0]   last_rk0, last_rk1;

    task automatic check(input string tag, input logic [131:0] obs, input logic [131:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // ---------------- reference model ----------------
    logic [7:0]  sb [256];
    logic [7:0]  rc [8];
    logic [31:0] mw [60];

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        for (int n = 0; n < 8; n++) begin
            if (b[0]) p = p ^ a;
            a = a[7] ? ((a << 1) ^ 8'h1b) : (a << 1);
            b = b >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] x, input int s);
        return (x << s) | (x >> (8 - s));
    endfunction

    // S-box from GF(2^8) inverse plus affine map
    task automatic build_tables();
        for (int x = 0; x < 256; x++) begin
            logic [7:0] inv = 8'h00;
            for (int y = 1; y < 256; y++) begin
                if (x != 0 && gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            end
            sb[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
        end
        rc[0] = 8'h00;
        rc[1] = 8'h01;
        for (int n = 2; n < 8; n++) rc[n] = gmul(rc[n-1], 8'h02);
    endtask

    function automatic logic [31:0] subw(input logic [31:0] x);
        return {sb[x[31:24]], sb[x[23:16]], sb[x[15:8]], sb[x[7:0]]};
    endfunction

    // Forward AES-256 key expansion
    task automatic expand(input logic [255:0] key);
        for (int i = 0; i < 8; i++) mw[i] = key[255 - 32*i -: 32];
        for (int i = 8; i < 60; i++) begin
            logic [31:0] t = mw[i-1];
            if (i % 8 == 0)      t = subw({t[23:0], t[31:24]}) ^ {rc[i/8], 24'h0};
            else if (i % 8 == 4) t = subw(t);
            mw[i] = mw[i-8] ^ t;
        end
    endtask

    // ---------------- driver tasks ----------------
    initial begin
        key_ready = 1'b1;
        forever begin
            @(posedge clk); #1;
            key_ready = ready_rand ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    task automatic start_run(input logic [255:0] key, input bit with_timing);
        expand(key);
        for (int r = 14; r >= 0; r--) begin
            exp_q.push_back({4'(r), mw[4*r], mw[4*r+1], mw[4*r+2], mw[4*r+3]});
            exp_cyc_q.push_back(r == 14 ? 1 : (r == 13 ? 2 : 7 + 5*(12 - r)));
        end
        last_rk0 = 'x;
        last_rk1 = 'x;
        @(posedge clk); #1;
        key_in = {mw[52], mw[53], mw[54], mw[55], mw[56], mw[57], mw[58], mw[59]};
        start  = 1'b1;
        t0     = cyc;
        timed  = with_timing;
        @(posedge clk); #1;
        start  = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        bit seen = 1'b0;
        for (int n = 0; n < 1000 && !seen; n++) begin
            @(negedge clk);
            if (timed && cyc - t0 == 30) check({tag, "_busy"}, 132'(busy), 132'(1));
            if (done) seen = 1'b1;
        end
        check({tag, "_done_seen"}, 132'(seen), 132'(1));
        if (seen && timed) check({tag, "_done_cycle"}, 132'(cyc - t0), 132'(68));
        check({tag, "_keys_left"}, 132'(exp_q.size()), 132'(0));
    endtask

    // ---------------- scoreboard monitor ----------------
    always @(negedge clk) begin
        if (!rst && key_valid) begin
            if (exp_q.size() == 0) begin
                check("unexpected_key", {round_idx, key_out}, 132'(0));
            end else begin
                check("key", {round_idx, key_out}, exp_q[0]);
                if (key_ready) begin
                    if (timed) check("latency", 132'(cyc - t0), 132'(exp_cyc_q[0]));
                    if (round_idx == 4'd0) last_rk0 = key_out;
                    if (round_idx == 4'd1) last_rk1 = key_out;
                    void'(exp_q.pop_front());
                    void'(exp_cyc_q.pop_front());
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- directed sequence ----------------
    localparam logic [255:0] KEY_FIPS = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    localparam logic [255:0] KEY_A3   = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;
    localparam logic [255:0] LAST_FIPS = 256'h4e5a6699a9f24fe07e572baacdf8cdea24fc79ccbf0979e9371ac23c6d68de36;

    initial begin
        rst    = 1'b1;
        start  = 1'b0;
        key_in = '0;
        build_tables();
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("rst_valid", 132'(key_valid), 132'(0));
        check("rst_key",   132'(key_out),   132'(0));
        check("rst_round", 132'(round_idx), 132'(0));
        check("rst_busy",  132'(busy),      132'(0));
        check("rst_done",  132'(done),      132'(0));
        check("rst_state", 132'(dut.state), 132'(ST_IDLE));

        expand(KEY_FIPS);
        check("model_last_keys", {mw[52], mw[53], mw[54], mw[55], mw[56], mw[57], mw[58], mw[59]}, 132'(LAST_FIPS));

        // FIPS key, ready tied high
        start_run(KEY_FIPS, 1'b1);
        wait_done("fips");
        check("fips_rk1", 132'(last_rk1), 132'(128'h101112131415161718191a1b1c1d1e1f));
        check("fips_rk0", 132'(last_rk0), 132'(128'h000102030405060708090a0b0c0d0e0f));

        // FIPS-197 A.3 key
        start_run(KEY_A3, 1'b1);
        wait_done("a3");
        check("a3_rk0", 132'(last_rk0), 132'(128'h603deb1015ca71be2b73aef0857d7781));

        // random backpressure
        ready_rand = 1'b1;
        start_run(KEY_A3, 1'b0);
        wait_done("bp");
        ready_rand = 1'b0;
        repeat (2) @(posedge clk);

        // start re-pulsed and key_in scrambled mid-run
        start_run(KEY_FIPS, 1'b1);
        repeat (18) @(posedge clk);
        #1;
        start  = 1'b1;
        key_in = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        @(posedge clk); #1;
        start  = 1'b0;
        wait_done("midstart");
        check("midstart_rk0", 132'(last_rk0), 132'(128'h000102030405060708090a0b0c0d0e0f));

        // reset while generating round 8
        start_run(KEY_FIPS, 1'b1);
        repeat (23) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        exp_q.delete();
        exp_cyc_q.delete();
        @(negedge clk);
        check("midrst_valid", 132'(key_valid), 132'(0));
        check("midrst_key",   132'(key_out),   132'(0));
        check("midrst_round", 132'(round_idx), 132'(0));
        check("midrst_busy",  132'(busy),      132'(0));
        check("midrst_done",  132'(done),      132'(0));
        check("midrst_state", 132'(dut.state), 132'(ST_IDLE));
        start_run(KEY_FIPS, 1'b1);
        wait_done("after_rst");

        // back-to-back: start in the cycle right after done
        start_run(KEY_A3, 1'b1);
        wait_done("b2b_first");
        start_run(KEY_FIPS, 1'b1);
        wait_done("b2b_second");
        check("b2b_rk0", 132'(last_rk0), 132'(128'h000102030405060708090a0b0c0d0e0f));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
